// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with PC register and IF/ID pipeline register.
// Latency: one cycle from IMemInstruction (at IMemAddress) to IF_ID_* outputs.
// Backpressure: Stall holds PC and IF/ID; IMemReady=0 holds PC and inserts bubbles.
//
// Ports:
//   Clock, Reset         rising-edge clock, asynchronous active-high reset
//   IMemAddress          PC driven straight from the PC register
//   IMemInstruction      instruction at IMemAddress, sampled at the edge
//   IMemReady            IMemInstruction valid this cycle
//   Stall, Flush         hazard-unit hold / squash controls
//   BranchTaken/Target   redirect from a later stage, highest priority
//   IF_ID_*              registered instruction, PC+4 and valid bit for decode
//   FetchCount           saturating count of instructions accepted into IF/ID
//   StallCount           saturating count of cycles held by Stall
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  output logic [31:0]          IMemAddress,
  input  logic [31:0]          IMemInstruction,
  input  logic                 IMemReady,
  input  logic                 Stall,
  input  logic                 Flush,
  input  logic                 BranchTaken,
  input  logic [31:0]          BranchTarget,
  output logic [31:0]          IF_ID_Instruction,
  output logic [31:0]          IF_ID_PCPlus4,
  output logic                 IF_ID_Valid,
  output logic [CNT_WIDTH-1:0] FetchCount,
  output logic [CNT_WIDTH-1:0] StallCount
);

  // Low two bits are forced to zero so the PC stays word-aligned whatever
  // the parameter override says.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [31:0]          pc_q,          pc_d;
  logic [31:0]          ifid_instr_q,  ifid_instr_d;
  logic [31:0]          ifid_pcp4_q,   ifid_pcp4_d;
  logic                 ifid_vld_q,    ifid_vld_d;
  logic [CNT_WIDTH-1:0] fetch_cnt_q,   fetch_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q,   stall_cnt_d;

  logic [31:0] pc_plus4;

  // Modulo-2^32 increment: 0xFFFFFFFC wraps to 0.
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pcp4_d  = ifid_pcp4_q;
    ifid_vld_d   = ifid_vld_q;
    fetch_cnt_d  = fetch_cnt_q;
    stall_cnt_d  = stall_cnt_q;

    if (BranchTaken) begin
      // Redirect wins over everything; the wrong-path fetch is discarded.
      pc_d         = {BranchTarget[31:2], 2'b00};
      ifid_instr_d = 32'h0;
      ifid_pcp4_d  = 32'h0;
      ifid_vld_d   = 1'b0;
    end else if (Stall) begin
      // PC holds; IF/ID holds unless decode also asks for a squash.
      if (Flush) begin
        ifid_instr_d = 32'h0;
        ifid_pcp4_d  = 32'h0;
        ifid_vld_d   = 1'b0;
      end
      if (stall_cnt_q != CNT_MAX) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end else if (Flush) begin
      // The fetch completing this cycle is dropped but the PC still moves
      // past it, so it is not re-fetched.
      ifid_instr_d = 32'h0;
      ifid_pcp4_d  = 32'h0;
      ifid_vld_d   = 1'b0;
      if (IMemReady) begin
        pc_d = pc_plus4;
      end
    end else if (!IMemReady) begin
      ifid_instr_d = 32'h0;
      ifid_pcp4_d  = 32'h0;
      ifid_vld_d   = 1'b0;
    end else begin
      pc_d         = pc_plus4;
      ifid_instr_d = IMemInstruction;
      ifid_pcp4_d  = pc_plus4;
      ifid_vld_d   = 1'b1;
      if (fetch_cnt_q != CNT_MAX) begin
        fetch_cnt_d = fetch_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc_q         <= RESET_PC_ALIGNED;
      ifid_instr_q <= 32'h0;
      ifid_pcp4_q  <= 32'h0;
      ifid_vld_q   <= 1'b0;
      fetch_cnt_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pcp4_q  <= ifid_pcp4_d;
      ifid_vld_q   <= ifid_vld_d;
      fetch_cnt_q  <= fetch_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign IMemAddress       = pc_q;
  assign IF_ID_Instruction = ifid_instr_q;
  assign IF_ID_PCPlus4     = ifid_pcp4_q;
  assign IF_ID_Valid       = ifid_vld_q;
  assign FetchCount        = fetch_cnt_q;
  assign StallCount        = stall_cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a default instance plus an instance with
// RESET_PC=0xFFFFFFFC and CNT_WIDTH=2 for wrap and saturation corners.
module tb_if_fetch_stage;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  // Instruction memory contents known to the bench.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    case (a)
      32'h0:   memfn = 32'h2008000A;
      32'h4:   memfn = 32'h20100005;
      32'h8:   memfn = 32'h02088020;
      32'hC:   memfn = 32'h00000000;
      default: memfn = {16'hA5A5, a[15:0]};
    endcase
  endfunction

  // ---------------- instance 0: default parameters ----------------
  logic        rst0, rdy0, stall0, flush0, br0;
  logic [31:0] tgt0, addr0, instr0, imem0, pcp40;
  logic        vld0;
  logic [15:0] fcnt0, scnt0;

  assign imem0 = memfn(addr0);

  if_fetch_stage dut0 (
    .Clock(clk), .Reset(rst0), .IMemAddress(addr0), .IMemInstruction(imem0),
    .IMemReady(rdy0), .Stall(stall0), .Flush(flush0), .BranchTaken(br0),
    .BranchTarget(tgt0), .IF_ID_Instruction(instr0), .IF_ID_PCPlus4(pcp40),
    .IF_ID_Valid(vld0), .FetchCount(fcnt0), .StallCount(scnt0)
  );

  // ---------------- instance 1: wrap + 2-bit counters ----------------
  logic        rst1, rdy1, stall1;
  logic [31:0] addr1, instr1, imem1, pcp41;
  logic        vld1;
  logic [1:0]  fcnt1, scnt1;

  assign imem1 = memfn(addr1);

  if_fetch_stage #(.RESET_PC(32'hFFFFFFFC), .CNT_WIDTH(2)) dut1 (
    .Clock(clk), .Reset(rst1), .IMemAddress(addr1), .IMemInstruction(imem1),
    .IMemReady(rdy1), .Stall(stall1), .Flush(1'b0), .BranchTaken(1'b0),
    .BranchTarget(32'h0), .IF_ID_Instruction(instr1), .IF_ID_PCPlus4(pcp41),
    .IF_ID_Valid(vld1), .FetchCount(fcnt1), .StallCount(scnt1)
  );

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset0();
    rst0 = 1'b1; rdy0 = 1'b1; stall0 = 1'b0; flush0 = 1'b0; br0 = 1'b0; tgt0 = 32'h0;
    tick();
    rst0 = 1'b0;
  endtask

  task automatic test_reset();
    reset0();
    tests++;
    if ({addr0, instr0, pcp40, vld0, fcnt0, scnt0} !== {32'h0, 32'h0, 32'h0, 1'b0, 16'h0, 16'h0}) begin
      fails++;
      $display("FAIL reset_state: got addr=%h instr=%h pcp4=%h vld=%b fc=%0d sc=%0d, want all zero",
               addr0, instr0, pcp40, vld0, fcnt0, scnt0);
    end
  endtask

  task automatic test_sequential_fetch();
    logic [31:0] exp_pc;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_pc = 32'(4 * (i + 1));
      tests++;
      if ({addr0, instr0, pcp40, vld0} !== {exp_pc, memfn(32'(4 * i)), exp_pc, 1'b1}) begin
        fails++;
        $display("FAIL seq_fetch[%0d]: got addr=%h instr=%h pcp4=%h vld=%b, want addr=%h instr=%h pcp4=%h vld=1",
                 i, addr0, instr0, pcp40, vld0, exp_pc, memfn(32'(4 * i)), exp_pc);
      end
    end
    tests++;
    if (fcnt0 !== 16'd4) begin
      fails++;
      $display("FAIL seq_fetch_count: got %0d, want 4", fcnt0);
    end
  endtask

  task automatic test_stall();
    reset0();
    tick(); tick();  // PC=8, IF/ID holds the PC=4 instruction
    stall0 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if ({addr0, instr0, pcp40, vld0} !== {32'h8, 32'h20100005, 32'h8, 1'b1}) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got addr=%h instr=%h pcp4=%h vld=%b, want 8/20100005/8/1",
                 i, addr0, instr0, pcp40, vld0);
      end
    end
    tests++;
    if ({scnt0, fcnt0} !== {16'd2, 16'd2}) begin
      fails++;
      $display("FAIL stall_counts: got sc=%0d fc=%0d, want sc=2 fc=2", scnt0, fcnt0);
    end
    stall0 = 1'b0;
    tick();
    tests++;
    if ({addr0, instr0, pcp40, vld0, fcnt0} !== {32'hC, 32'h02088020, 32'hC, 1'b1, 16'd3}) begin
      fails++;
      $display("FAIL stall_release: got addr=%h instr=%h pcp4=%h vld=%b fc=%0d, want C/02088020/C/1/3",
               addr0, instr0, pcp40, vld0, fcnt0);
    end
  endtask

  task automatic test_branch_over_stall();
    // Continues from PC=C with StallCount=2, FetchCount=3.
    br0 = 1'b1; tgt0 = 32'h00000043; stall0 = 1'b1; flush0 = 1'b1; rdy0 = 1'b0;
    tick();
    br0 = 1'b0; stall0 = 1'b0; flush0 = 1'b0; rdy0 = 1'b1;
    tests++;
    if ({addr0, instr0, pcp40, vld0, scnt0, fcnt0} !== {32'h40, 32'h0, 32'h0, 1'b0, 16'd2, 16'd3}) begin
      fails++;
      $display("FAIL branch: got addr=%h instr=%h pcp4=%h vld=%b sc=%0d fc=%0d, want 40/0/0/0/2/3",
               addr0, instr0, pcp40, vld0, scnt0, fcnt0);
    end
    tick();
    tests++;
    if ({addr0, instr0, pcp40, vld0} !== {32'h44, memfn(32'h40), 32'h44, 1'b1}) begin
      fails++;
      $display("FAIL branch_target_fetch: got addr=%h instr=%h pcp4=%h vld=%b, want 44/%h/44/1",
               addr0, instr0, pcp40, vld0, memfn(32'h40));
    end
  endtask

  task automatic test_imem_wait();
    reset0();
    for (int i = 0; i < 4; i++) tick();  // PC=10
    rdy0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({addr0, instr0, pcp40, vld0, fcnt0} !== {32'h10, 32'h0, 32'h0, 1'b0, 16'd4}) begin
        fails++;
        $display("FAIL imem_wait[%0d]: got addr=%h instr=%h pcp4=%h vld=%b fc=%0d, want 10/0/0/0/4",
                 i, addr0, instr0, pcp40, vld0, fcnt0);
      end
    end
    rdy0 = 1'b1;
    tick();
    tests++;
    if ({addr0, instr0, pcp40, vld0, fcnt0} !== {32'h14, memfn(32'h10), 32'h14, 1'b1, 16'd5}) begin
      fails++;
      $display("FAIL imem_resume: got addr=%h instr=%h pcp4=%h vld=%b fc=%0d, want 14/%h/14/1/5",
               addr0, instr0, pcp40, vld0, fcnt0, memfn(32'h10));
    end
  endtask

  task automatic test_flush();
    // Continues from PC=14, FetchCount=5, StallCount=0.
    flush0 = 1'b1; stall0 = 1'b1;
    tick();
    tests++;
    if ({addr0, instr0, pcp40, vld0, scnt0, fcnt0} !== {32'h14, 32'h0, 32'h0, 1'b0, 16'd1, 16'd5}) begin
      fails++;
      $display("FAIL flush_stall: got addr=%h instr=%h pcp4=%h vld=%b sc=%0d fc=%0d, want 14/0/0/0/1/5",
               addr0, instr0, pcp40, vld0, scnt0, fcnt0);
    end
    stall0 = 1'b0;
    tick();  // flush with memory ready: PC advances, fetch not counted
    tests++;
    if ({addr0, vld0, instr0, scnt0, fcnt0} !== {32'h18, 1'b0, 32'h0, 16'd1, 16'd5}) begin
      fails++;
      $display("FAIL flush_ready: got addr=%h vld=%b instr=%h sc=%0d fc=%0d, want 18/0/0/1/5",
               addr0, vld0, instr0, scnt0, fcnt0);
    end
    rdy0 = 1'b0;
    tick();  // flush with memory not ready: PC holds
    tests++;
    if ({addr0, vld0} !== {32'h18, 1'b0}) begin
      fails++;
      $display("FAIL flush_not_ready: got addr=%h vld=%b, want 18/0", addr0, vld0);
    end
    flush0 = 1'b0; rdy0 = 1'b1;
  endtask

  task automatic test_async_reset();
    reset0();
    tick(); tick();
    stall0 = 1'b1;
    tick();  // mid-stall: PC=8, StallCount=1
    @(posedge clk);
    #3;
    rst0 = 1'b1;
    #1;
    tests++;
    if ({addr0, instr0, pcp40, vld0, fcnt0, scnt0} !== {32'h0, 32'h0, 32'h0, 1'b0, 16'h0, 16'h0}) begin
      fails++;
      $display("FAIL async_reset: got addr=%h instr=%h pcp4=%h vld=%b fc=%0d sc=%0d, want all zero",
               addr0, instr0, pcp40, vld0, fcnt0, scnt0);
    end
    stall0 = 1'b0;
    tick();
    rst0 = 1'b0;
    tick();
    tests++;
    if ({addr0, instr0, pcp40, vld0, fcnt0} !== {32'h4, 32'h2008000A, 32'h4, 1'b1, 16'd1}) begin
      fails++;
      $display("FAIL after_async_reset: got addr=%h instr=%h pcp4=%h vld=%b fc=%0d, want 4/2008000A/4/1/1",
               addr0, instr0, pcp40, vld0, fcnt0);
    end
  endtask

  task automatic test_wrap_and_saturation();
    rst1 = 1'b1; rdy1 = 1'b1; stall1 = 1'b0;
    tick();
    rst1 = 1'b0;
    tests++;
    if ({addr1, vld1, fcnt1, scnt1} !== {32'hFFFFFFFC, 1'b0, 2'd0, 2'd0}) begin
      fails++;
      $display("FAIL wrap_reset_pc: got addr=%h vld=%b fc=%0d sc=%0d, want FFFFFFFC/0/0/0",
               addr1, vld1, fcnt1, scnt1);
    end
    tick();
    tests++;
    if ({addr1, instr1, pcp41, vld1} !== {32'h0, 32'hA5A5FFFC, 32'h0, 1'b1}) begin
      fails++;
      $display("FAIL wrap_pcplus4: got addr=%h instr=%h pcp4=%h vld=%b, want 0/A5A5FFFC/0/1",
               addr1, instr1, pcp41, vld1);
    end
    for (int i = 0; i < 4; i++) tick();
    tests++;
    if ({fcnt1, addr1} !== {2'd3, 32'h10}) begin
      fails++;
      $display("FAIL fetch_saturate: got fc=%0d addr=%h, want fc=3 addr=10", fcnt1, addr1);
    end
    stall1 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    stall1 = 1'b0;
    tests++;
    if ({scnt1, fcnt1, addr1} !== {2'd3, 2'd3, 32'h10}) begin
      fails++;
      $display("FAIL stall_saturate: got sc=%0d fc=%0d addr=%h, want 3/3/10", scnt1, fcnt1, addr1);
    end
  endtask

  initial begin
    rst0 = 1'b1; rdy0 = 1'b1; stall0 = 1'b0; flush0 = 1'b0; br0 = 1'b0; tgt0 = 32'h0;
    rst1 = 1'b1; rdy1 = 1'b1; stall1 = 1'b0;
    test_reset();
    test_sequential_fetch();
    test_stall();
    test_branch_over_stall();
    test_imem_wait();
    test_flush();
    test_async_reset();
    test_wrap_and_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
